riscv_apu_disp_fifo: RTL

// - Parametrised APU dispatcher. Issues core requests to the APU interconnect.
// - Tracks up to DEPTH in-flight operations in an in-order tag FIFO.
// - Checks read/write hazards against every outstanding destination and returns the write address with each response.
// - Sits between the ID/EX stage and the APU master port.

---
 rtl/riscv_apu_disp_fifo_if.sv | 17 +
 rtl/riscv_apu_disp_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/riscv_apu_disp_fifo_if.sv
// ---------------------------------------------------------------------------
// riscv_apu_disp_fifo_if
// Handshake bundle between the APU dispatcher and the APU interconnect.
//   req   : dispatcher -> interconnect, request an operation
//   gnt   : interconnect -> dispatcher, request granted this cycle
//   valid : interconnect -> dispatcher, a result is returning this cycle
//   ready : dispatcher -> interconnect, result accepted (always 1)
// ---------------------------------------------------------------------------
interface riscv_apu_disp_fifo_if;
  logic req;
  logic gnt;
  logic valid;
  logic ready;

  modport master (output req, output ready, input gnt, input valid);
  modport slave  (input req, input ready, output gnt, output valid);
endinterface

// File: rtl/riscv_apu_disp_fifo.sv
// ---------------------------------------------------------------------------
// riscv_apu_disp_fifo
// APU dispatcher: issues core requests to the APU interconnect, tracks up to
// DEPTH accepted-but-unreturned operations in an in-order destination FIFO,
// flags RAW/WAW hazards of the ID instruction against outstanding results and
// returns the destination address with every response.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   enable_i, apu_lat_i       issue request and its latency class (1/2/3)
//   apu_waddr_i               destination of the issuing op
//   read_regs_i/_valid_i      ID source registers for RAW checking
//   write_regs_i/_valid_i     ID destination registers for WAW checking
//   read_dep_o, write_dep_o   hazard flags
//   stall_o, perf_type_o, perf_cont_o  stall and its type/nack components
//   active_o, count_o         outstanding status
//   apu_waddr_o               destination of the returning op (0 if none)
//   apu_singlecycle_o, apu_multicycle_o  latency status
//   err_o                     sticky: response arrived with nothing outstanding
//   apu_master                request/grant/response handshake (master side)
// ---------------------------------------------------------------------------
module riscv_apu_disp_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_READ   = 3,
  parameter int unsigned NUM_WRITE  = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic [1:0]                      apu_lat_i,
  input  logic [ADDR_WIDTH-1:0]           apu_waddr_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  read_regs_i,
  input  logic [NUM_READ-1:0]             read_regs_valid_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_regs_i,
  input  logic [NUM_WRITE-1:0]            write_regs_valid_i,
  output logic                            read_dep_o,
  output logic                            write_dep_o,
  output logic                            stall_o,
  output logic                            perf_type_o,
  output logic                            perf_cont_o,
  output logic                            active_o,
  output logic [CW-1:0]                   count_o,
  output logic [ADDR_WIDTH-1:0]           apu_waddr_o,
  output logic                            apu_singlecycle_o,
  output logic                            apu_multicycle_o,
  output logic                            err_o,
  riscv_apu_disp_fifo_if.master           apu_master
);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [1:0]            r_lat;
  logic                  r_err;

  logic w_active, w_full, w_stall_type, w_valid_req, w_stall_nack;
  logic w_accept, w_returned, w_push, w_pop, w_err_set;
  logic w_read_dep, w_write_dep;

  function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) n = '0;
    else                     n = p + PW'(1);
    return n;
  endfunction

  function automatic logic f_read_hit(input logic [ADDR_WIDTH-1:0] a,
                                      input logic [NUM_READ*ADDR_WIDTH-1:0] regs,
                                      input logic [NUM_READ-1:0] vld);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < NUM_READ; r++)
      hit = hit | (vld[r] & (regs[r*ADDR_WIDTH +: ADDR_WIDTH] == a));
    return hit;
  endfunction

  function automatic logic f_write_hit(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [NUM_WRITE*ADDR_WIDTH-1:0] regs,
                                       input logic [NUM_WRITE-1:0] vld);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < NUM_WRITE; r++)
      hit = hit | (vld[r] & (regs[r*ADDR_WIDTH +: ADDR_WIDTH] == a));
    return hit;
  endfunction

  // Issue/accept/return decode; a lower latency class behind a longer one
  // would overtake it, so single/multicycle ops wait for an empty pipe.
  assign w_active     = (r_count != '0);
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_stall_type = enable_i & w_active &
                        ((apu_lat_i == 2'd1) | (apu_lat_i == 2'd3) | (apu_lat_i < r_lat));
  assign w_valid_req  = enable_i & ~w_full & ~w_stall_type;
  assign w_stall_nack = w_valid_req & ~apu_master.gnt;
  assign w_accept     = w_valid_req & apu_master.gnt;
  assign w_returned   = w_accept & apu_master.valid & ~w_active;
  assign w_push       = w_accept & ~w_returned;
  assign w_pop        = apu_master.valid & w_active;
  assign w_err_set    = apu_master.valid & ~w_active & ~w_returned;

  // Hazard check against the live request and every entry that survives this cycle.
  always_comb begin
    w_read_dep  = w_valid_req & ~w_returned &
                  f_read_hit(apu_waddr_i, read_regs_i, read_regs_valid_i);
    w_write_dep = w_valid_req & ~w_returned &
                  f_write_hit(apu_waddr_i, write_regs_i, write_regs_valid_i);
    for (int i = 0; i < DEPTH; i++) begin
      w_read_dep  = w_read_dep | (r_vld[i] & ~(w_pop & (r_rd_ptr == PW'(i))) &
                    f_read_hit(r_addr[i], read_regs_i, read_regs_valid_i));
      w_write_dep = w_write_dep | (r_vld[i] & ~(w_pop & (r_rd_ptr == PW'(i))) &
                    f_write_hit(r_addr[i], write_regs_i, write_regs_valid_i));
    end
  end

  // Response address: FIFO head when something is outstanding, else the op returning now.
  always_comb begin
    if (apu_master.valid) begin
      if (w_active) apu_waddr_o = r_addr[r_rd_ptr];
      else          apu_waddr_o = apu_waddr_i;
    end else begin
      apu_waddr_o = '0;
    end
  end

  // FIFO storage, pointers, count, latency class and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr   <= '{default: '0};
      r_vld    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_lat    <= 2'd0;
      r_err    <= 1'b0;
    end else begin
      // Pop before push; they never target the same slot because push is blocked when full.
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= f_ptr_next(r_rd_ptr);
      end
      if (w_push) begin
        r_addr[r_wr_ptr] <= apu_waddr_i;
        r_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr         <= f_ptr_next(r_wr_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept)  r_lat <= apu_lat_i;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign apu_master.req   = w_valid_req;
  assign apu_master.ready = 1'b1;
  assign read_dep_o        = w_read_dep;
  assign write_dep_o       = w_write_dep;
  assign stall_o           = w_full | w_stall_type | w_stall_nack;
  assign perf_type_o       = w_stall_type;
  assign perf_cont_o       = w_stall_nack;
  assign active_o          = w_active;
  assign count_o           = r_count;
  assign apu_singlecycle_o = ~w_active;
  assign apu_multicycle_o  = (r_lat == 2'd3);
  assign err_o             = r_err;

endmodule
